// File: rtl/combinational_circuit_pkg.sv
// Shared widths and pure transform functions for the fitness-timer byte transform.
// The RTL core and the bench model both build on these functions.
package combinational_circuit_pkg;

  localparam int WIDTH    = 8;
  localparam int ROT_BITS = 3;

  typedef logic [WIDTH-1:0]    byte_t;
  typedef logic [ROT_BITS-1:0] rot_t;
  typedef logic [ROT_BITS:0]   pop_t;

  // Binary-to-Gray: each bit XORed with its more significant neighbour.
  function automatic byte_t gray8(input byte_t value);
    return value ^ (value >> 1);
  endfunction

  // Rotate left; the 3-bit index add wraps modulo WIDTH on its own.
  function automatic byte_t rotl8(input byte_t value, input rot_t amt);
    byte_t result;
    rot_t  idx;
    result = '0;
    for (int i = 0; i < WIDTH; i++) begin
      idx         = rot_t'(i) + amt;
      result[idx] = value[i];
    end
    return result;
  endfunction

  function automatic pop_t popcount8(input byte_t value);
    pop_t cnt;
    cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt = cnt + pop_t'(value[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/combinational_circuit_core.sv
// Pure combinational mapping input_bits -> t3_next through the Gray,
// rotate and popcount-add stages.
module combinational_circuit_core
  import combinational_circuit_pkg::*;
(
  input  logic [WIDTH-1:0] input_bits,
  output logic [WIDTH-1:0] t3_next
);

  byte_t t1;
  byte_t t2;
  pop_t  pop;

  always_comb begin
    t1      = gray8(input_bits);
    t2      = rotl8(t1, input_bits[ROT_BITS-1:0]);
    pop     = popcount8(input_bits);
    // Carry-out is intentionally dropped: the sum wraps modulo 256.
    t3_next = t2 + byte_t'(pop);
  end

endmodule

// File: rtl/combinational_circuit.sv
// Registered byte transform: one input sampled per clock, result on T3
// exactly one cycle later, out_valid marks the first sampled result after reset.
module combinational_circuit
  import combinational_circuit_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] input_bits,
  output logic [WIDTH-1:0] T3,
  output logic             out_valid
);

  byte_t t3_next;

  combinational_circuit_core u_core (
    .input_bits (input_bits),
    .t3_next    (t3_next)
  );

  // No handshake: every edge out of reset captures a fresh result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      T3        <= '0;
      out_valid <= 1'b0;
    end else begin
      T3        <= t3_next;
      out_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_combinational_circuit.sv
// Directed bench for combinational_circuit: hand-computed vectors for reset,
// rotate/popcount corners, back-to-back streaming and asynchronous reset.
module tb_combinational_circuit;

  logic       clk;
  logic       rst_n;
  logic [7:0] input_bits;
  logic [7:0] T3;
  logic       out_valid;

  int errors = 0;
  int checks = 0;

  combinational_circuit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .input_bits (input_bits),
    .T3         (T3),
    .out_valid  (out_valid)
  );

  // Clock and reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: present a byte on the falling edge, away from sampling.
  task automatic drive(input logic [7:0] value);
    @(negedge clk);
    input_bits = value;
  endtask

  task automatic sample_after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    input_bits = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (T3 !== 8'h00) begin
      errors++;
      $display("FAIL reset_t3: got %0d expected 0", T3);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %b expected 0", out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    sample_after_edge();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL release_valid: got %b expected 1", out_valid);
    end
    checks++;
    if (T3 !== 8'd72) begin
      errors++;
      $display("FAIL release_t3: got %0d expected 72", T3);
    end
  endtask

  task automatic test_identity();
    drive(8'h00);
    sample_after_edge();
    checks++;
    if (T3 !== 8'd0) begin
      errors++;
      $display("FAIL identity_00: got %0d expected 0", T3);
    end
    drive(8'h01);
    sample_after_edge();
    checks++;
    if (T3 !== 8'd3) begin
      errors++;
      $display("FAIL identity_01: got %0d expected 3", T3);
    end
  endtask

  task automatic test_rotate_zero();
    drive(8'h80);
    sample_after_edge();
    checks++;
    if (T3 !== 8'hC1) begin
      errors++;
      $display("FAIL rot0_80: got %h expected c1", T3);
    end
    // 3C: gray 22, rotl 4 -> 22, +4 -> 26
    drive(8'h3C);
    sample_after_edge();
    checks++;
    if (T3 !== 8'h26) begin
      errors++;
      $display("FAIL rot4_3c: got %h expected 26", T3);
    end
  endtask

  task automatic test_wrap();
    drive(8'hA5);
    sample_after_edge();
    checks++;
    if (T3 !== 8'd2) begin
      errors++;
      $display("FAIL wrap_a5: got %0d expected 2", T3);
    end
    // 55: gray 7F, rotl 5 -> EF, +4 -> F3
    drive(8'h55);
    sample_after_edge();
    checks++;
    if (T3 !== 8'hF3) begin
      errors++;
      $display("FAIL rot5_55: got %h expected f3", T3);
    end
  endtask

  task automatic test_rotate7();
    drive(8'h07);
    sample_after_edge();
    checks++;
    if (T3 !== 8'd5) begin
      errors++;
      $display("FAIL rot7_07: got %0d expected 5", T3);
    end
    drive(8'hFF);
    sample_after_edge();
    checks++;
    if (T3 !== 8'd72) begin
      errors++;
      $display("FAIL rot7_ff: got %0d expected 72", T3);
    end
  endtask

  task automatic test_hold();
    drive(8'hA5);
    for (int i = 0; i < 3; i++) begin
      sample_after_edge();
      checks++;
      if (T3 !== 8'd2) begin
        errors++;
        $display("FAIL hold_a5[%0d]: got %0d expected 2", i, T3);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] vec [4];
    logic [7:0] exp [4];
    logic [7:0] prev;
    vec[0] = 8'h00; exp[0] = 8'd0;
    vec[1] = 8'hA5; exp[1] = 8'd2;
    vec[2] = 8'hFF; exp[2] = 8'd72;
    vec[3] = 8'h80; exp[3] = 8'd193;
    prev = 8'd2;
    for (int i = 0; i < 4; i++) begin
      drive(vec[i]);
      #1;
      // Before the edge T3 must still show the previous result.
      checks++;
      if (T3 !== prev) begin
        errors++;
        $display("FAIL b2b_pre[%0d]: got %0d expected %0d", i, T3, prev);
      end
      sample_after_edge();
      checks++;
      if (T3 !== exp[i]) begin
        errors++;
        $display("FAIL b2b[%0d]: got %0d expected %0d", i, T3, exp[i]);
      end
      prev = exp[i];
    end
  endtask

  task automatic test_async_reset();
    drive(8'hFF);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (T3 !== 8'd0) begin
      errors++;
      $display("FAIL async_t3: got %0d expected 0", T3);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_valid: got %b expected 0", out_valid);
    end
    sample_after_edge();
    checks++;
    if (T3 !== 8'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_hold: got t3=%0d valid=%b expected t3=0 valid=0", T3, out_valid);
    end
    drive(8'h01);
    rst_n = 1'b1;
    sample_after_edge();
    checks++;
    if (T3 !== 8'd3 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL async_release: got t3=%0d valid=%b expected t3=3 valid=1", T3, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_rotate_zero();
    test_wrap();
    test_rotate7();
    test_hold();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
